// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter sharing one WIDTH-bit adder among NREQ
// requesters. The winning operand pair is added and the result is held in a
// one-deep response register drained through a valid/ready handshake.
// Optional feature macro: ADD_SHARE_ARB_OVF_EN adds rsp_ovf, the signed
// overflow flag of the registered addition.
module add_share_arb #(
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       gnt,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_carry,
`ifdef ADD_SHARE_ARB_OVF_EN
   output logic                  rsp_ovf,
`endif
   input  logic                  rsp_ready
);

   // Unsigned wrap-around add; the extra top bit is the carry-out.
   function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

`ifdef ADD_SHARE_ARB_OVF_EN
   // Two's-complement overflow: operands agree in sign, sum does not.
   function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b,
                                       input logic signed [WIDTH-1:0] s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction
`endif

   logic [WIDTH-1:0] a_arr [NREQ];
   logic [WIDTH-1:0] b_arr [NREQ];
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic             accept;
   logic [WIDTH:0]   add_res;

   logic             vld_p1;
   logic [IDW-1:0]   id_p1;
   logic [WIDTH-1:0] sum_p1;
   logic             carry_p1;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   // Nothing is granted during reset or while the result register is stuck.
   assign accept  = rst_n & (~vld_p1 | rsp_ready) & (|req);
   assign add_res = add_wrap(a_arr[win], b_arr[win]);

   // Cyclic search for the first requester at or above ptr.
   always_comb begin
      logic [IDW:0] cand;
      logic         found;
      cand  = '0;
      found = 1'b0;
      win   = '0;
      gnt   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ))
            cand = cand - (IDW+1)'(NREQ);
         if (!found && req[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
      if (accept)
         gnt[win] = 1'b1;
   end

   // Stage 1: capture the winner's sum, or drain/hold the response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         id_p1    <= '0;
         sum_p1   <= '0;
         carry_p1 <= 1'b0;
         ptr      <= '0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         id_p1    <= win;
         sum_p1   <= add_res[WIDTH-1:0];
         carry_p1 <= add_res[WIDTH];
         ptr      <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      end else if (rsp_ready) begin
         vld_p1   <= 1'b0;
      end
   end

`ifdef ADD_SHARE_ARB_OVF_EN
   logic ovf_p1;

   // Stage 1 overflow flag, captured and held together with the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_p1 <= 1'b0;
      else if (accept)
         ovf_p1 <= signed_ovf(a_arr[win], b_arr[win], add_res[WIDTH-1:0]);
   end

   assign rsp_ovf = ovf_p1;
`endif

   assign rsp_valid = vld_p1;
   assign rsp_id    = id_p1;
   assign rsp_sum   = sum_p1;
   assign rsp_carry = carry_p1;

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: directed bench for add_share_arb (NREQ=4, WIDTH=32).
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, gnt 1 time unit after inputs change.
module tb_add_share_arb;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int WIDTH = 32;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       gnt;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_carry;
   logic                  rsp_ready;
`ifdef ADD_SHARE_ARB_OVF_EN
   logic                  rsp_ovf;
`endif

   int checks = 0;
   int errors = 0;

   add_share_arb #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
`ifdef ADD_SHARE_ARB_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   // Round-robin expectations starting from ptr=1 (left there by test 1).
   int               rr_order [5] = '{1, 2, 3, 0, 1};
   logic [WIDTH-1:0] rr_sum   [4] = '{32'h10, 32'h21, 32'h32, 32'h43};

   initial begin
      rst_n     = 1'b0;
      req       = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      // Reset state, including gnt forced low despite pending requests
      #2;
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_id",    64'(rsp_id),    64'd0);
      chk("rst_sum",   64'(rsp_sum),   64'd0);
      chk("rst_carry", 64'(rsp_carry), 64'd0);
      chk("rst_gnt",   64'(gnt),       64'd0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: single request 5+7
      @(negedge clk);
      req = 4'b0001; set_op(0, 32'd5, 32'd7); rsp_ready = 1'b1;
      #1 chk("t1_gnt", 64'(gnt), 64'h1);
      @(posedge clk); #1;
      chk("t1_valid", 64'(rsp_valid), 64'd1);
      chk("t1_id",    64'(rsp_id),    64'd0);
      chk("t1_sum",   64'(rsp_sum),   64'd12);
      chk("t1_carry", 64'(rsp_carry), 64'd0);
      @(negedge clk);
      req = '0;
      #1 chk("t1_idle_gnt", 64'(gnt), 64'd0);
      @(posedge clk); #1;
      chk("t1_drained", 64'(rsp_valid), 64'd0);

      // Test 2: all four requesting, back-to-back grants, no bubbles
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h10 * (i + 1), i);
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1 chk("t2_gnt", 64'(gnt), 64'(4'b0001 << rr_order[c]));
         @(posedge clk); #1;
         chk("t2_valid", 64'(rsp_valid), 64'd1);
         chk("t2_id",    64'(rsp_id),    64'(rr_order[c]));
         chk("t2_sum",   64'(rsp_sum),   64'(rr_sum[rr_order[c]]));
         @(negedge clk);
      end

      // Test 3: backpressure for 3 cycles while requester 2 waits
      rsp_ready = 1'b0; req = 4'b0100; set_op(2, 32'h1000, 32'h234);
      for (int c = 0; c < 3; c++) begin
         #1 chk("t3_bp_gnt", 64'(gnt), 64'd0);
         @(posedge clk); #1;
         chk("t3_bp_sum",   64'(rsp_sum),   64'h21);
         chk("t3_bp_valid", 64'(rsp_valid), 64'd1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 chk("t3_gnt", 64'(gnt), 64'h4);
      @(posedge clk); #1;
      chk("t3_sum", 64'(rsp_sum), 64'h1234);
      chk("t3_id",  64'(rsp_id),  64'd2);

      // Test 4: unsigned wrap with carry, then signed overflow case
      @(negedge clk);
      req = 4'b1000; set_op(3, 32'hFFFF_FFFF, 32'h1);
      #1 chk("t4_gnt", 64'(gnt), 64'h8);
      @(posedge clk); #1;
      chk("t4_sum",   64'(rsp_sum),   64'd0);
      chk("t4_carry", 64'(rsp_carry), 64'd1);
      chk("t4_id",    64'(rsp_id),    64'd3);
`ifdef ADD_SHARE_ARB_OVF_EN
      chk("t4_ovf0",  64'(rsp_ovf),   64'd0);
`endif
      @(negedge clk);
      req = 4'b0001; set_op(0, 32'h7FFF_FFFF, 32'h1);
      #1 chk("t4b_gnt", 64'(gnt), 64'h1);
      @(posedge clk); #1;
      chk("t4b_sum",   64'(rsp_sum),   64'h8000_0000);
      chk("t4b_carry", 64'(rsp_carry), 64'd0);
`ifdef ADD_SHARE_ARB_OVF_EN
      chk("t4b_ovf",   64'(rsp_ovf),   64'd1);
`endif

      // Test 5: reset pulse while a result is pending and req=1010
      @(negedge clk);
      req = 4'b1010; rsp_ready = 1'b0; set_op(1, 32'h20, 32'h1);
      #1 chk("t5_hold_gnt", 64'(gnt), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(rsp_valid), 64'd0);
      chk("t5_rst_sum",   64'(rsp_sum),   64'd0);
      chk("t5_rst_gnt",   64'(gnt),       64'd0);
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1;
      #1 chk("t5_gnt1", 64'(gnt), 64'h2);
      @(posedge clk); #1;
      chk("t5_valid1", 64'(rsp_valid), 64'd1);
      chk("t5_id1",    64'(rsp_id),    64'd1);
      chk("t5_sum1",   64'(rsp_sum),   64'h21);
      @(negedge clk);
      #1 chk("t5_gnt2", 64'(gnt), 64'h8);
      @(posedge clk); #1;
      chk("t5_id2",    64'(rsp_id),    64'd3);
      chk("t5_sum2",   64'(rsp_sum),   64'd0);
      chk("t5_carry2", 64'(rsp_carry), 64'd1);
      @(negedge clk);
      req = '0;
      @(posedge clk); #1;
      chk("t5_drained", 64'(rsp_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
